// File: rtl/mem_bus_arbiter_if.sv
// rtl/mem_bus_arbiter_if.sv - requester-side handshake bundle for mem_bus_arbiter
// Master modport is the datapath/control side; slave modport is the arbiter.
interface mem_bus_arbiter_if #(
    parameter int WORD_SIZE = 16,
    parameter int CNT_WIDTH = 16
);
    logic                 i_req;
    logic [WORD_SIZE-1:0] i_addr;
    logic                 i_ack;
    logic                 d_req;
    logic                 d_we;
    logic [WORD_SIZE-1:0] d_addr;
    logic [WORD_SIZE-1:0] d_wdata;
    logic                 d_ack;
    logic [WORD_SIZE-1:0] rdata;
    logic [CNT_WIDTH-1:0] i_cnt;
    logic [CNT_WIDTH-1:0] d_cnt;

    modport master (
        output i_req, i_addr, d_req, d_we, d_addr, d_wdata,
        input  i_ack, d_ack, rdata, i_cnt, d_cnt
    );

    modport slave (
        input  i_req, i_addr, d_req, d_we, d_addr, d_wdata,
        output i_ack, d_ack, rdata, i_cnt, d_cnt
    );
endinterface

// File: rtl/mem_bus_arbiter.sv
// rtl/mem_bus_arbiter.sv - round-robin I/D arbiter for a fixed-latency single-port memory bus
// One access in flight at a time: IDLE grants, BUSY holds the strobe, RESP acks the owner.
module mem_bus_arbiter #(
    parameter int WORD_SIZE   = 16,
    parameter int MEM_LATENCY = 2,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    mem_bus_arbiter_if.slave     bus,
    output logic                 readM,
    output logic                 writeM,
    output logic [WORD_SIZE-1:0] address,
    inout  wire  [WORD_SIZE-1:0] data
);
    localparam int               LAT_W    = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
    localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(MEM_LATENCY - 1);
    localparam logic             OWN_I    = 1'b0;
    localparam logic             OWN_D    = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUSY,
        ST_RESP
    } state_t;

    state_t               r_state;
    state_t               w_next_state;
    logic                 r_owner;
    logic                 r_we;
    logic                 r_prio;
    logic [WORD_SIZE-1:0] r_addr;
    logic [WORD_SIZE-1:0] r_wdata;
    logic [WORD_SIZE-1:0] r_rdata;
    logic [LAT_W-1:0]     r_lat_cnt;
    logic [CNT_WIDTH-1:0] r_i_cnt;
    logic [CNT_WIDTH-1:0] r_d_cnt;

    logic                 w_grant;
    logic                 w_grant_d;
    logic                 w_lat_done;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // D wins only when I is idle or when the priority token points at D.
    always_comb begin
        w_next_state = r_state;
        w_grant      = 1'b0;
        w_grant_d    = 1'b0;
        w_lat_done   = (r_lat_cnt == '0);
        case (r_state)
            ST_IDLE: begin
                if (bus.i_req || bus.d_req) begin
                    w_grant      = 1'b1;
                    w_grant_d    = bus.d_req && (!bus.i_req || (r_prio == OWN_D));
                    w_next_state = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (w_lat_done) begin
                    w_next_state = ST_RESP;
                end
            end
            ST_RESP: begin
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_owner   <= OWN_I;
            r_we      <= 1'b0;
            r_prio    <= OWN_D;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_rdata   <= '0;
            r_lat_cnt <= '0;
            r_i_cnt   <= '0;
            r_d_cnt   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_grant) begin
                        r_owner   <= w_grant_d;
                        r_addr    <= w_grant_d ? bus.d_addr : bus.i_addr;
                        r_we      <= w_grant_d & bus.d_we;
                        r_wdata   <= bus.d_wdata;
                        // Token goes to the loser, even when the grant was uncontended.
                        r_prio    <= ~w_grant_d;
                        r_lat_cnt <= LAT_LOAD;
                    end
                end
                ST_BUSY: begin
                    if (!w_lat_done) begin
                        r_lat_cnt <= r_lat_cnt - LAT_W'(1);
                    end else if (!r_we) begin
                        r_rdata <= data;
                    end
                end
                ST_RESP: begin
                    if (r_owner == OWN_D) begin
                        r_d_cnt <= r_d_cnt + CNT_WIDTH'(1);
                    end else begin
                        r_i_cnt <= r_i_cnt + CNT_WIDTH'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign readM     = (r_state == ST_BUSY) && !r_we;
    assign writeM    = (r_state == ST_BUSY) && r_we;
    assign address   = r_addr;
    assign data      = writeM ? r_wdata : {WORD_SIZE{1'bz}};

    assign bus.i_ack = (r_state == ST_RESP) && (r_owner == OWN_I);
    assign bus.d_ack = (r_state == ST_RESP) && (r_owner == OWN_D);
    assign bus.rdata = r_rdata;
    assign bus.i_cnt = r_i_cnt;
    assign bus.d_cnt = r_d_cnt;
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb/tb_mem_bus_arbiter.sv - vector-table and scoreboard bench for mem_bus_arbiter
// Memory model idles the bus at KEEP so a released data bus is observable.
module tb_mem_bus_arbiter;
    localparam int          WS   = 16;
    localparam int          LAT  = 2;
    localparam int          CW   = 4;
    localparam logic [15:0] KEEP = 16'hDEAD;

    typedef struct {
        logic        is_d;
        logic        we;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] exp_rdata;
    } vec_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          readM;
    logic          writeM;
    logic [WS-1:0] address;
    wire  [WS-1:0] data;
    logic [15:0]   mem [0:255];

    vec_t          sb_q [$];
    vec_t          tbl  [10];
    int            n_pass;
    int            n_total;
    int            cyc;
    int            n_acks;
    int            ack_cyc;
    int            n_strobe;
    logic [CW-1:0] m_i;
    logic [CW-1:0] m_d;

    mem_bus_arbiter_if #(.WORD_SIZE(WS), .CNT_WIDTH(CW)) bus ();

    mem_bus_arbiter #(
        .WORD_SIZE  (WS),
        .MEM_LATENCY(LAT),
        .CNT_WIDTH  (CW)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .bus    (bus),
        .readM  (readM),
        .writeM (writeM),
        .address(address),
        .data   (data)
    );

    always #5 clk = ~clk;

    assign data = writeM ? {WS{1'bz}} : (readM ? mem[address[7:0]] : KEEP);

    function automatic logic [15:0] pat(input int a);
        return {a[7:0], ~a[7:0]};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic fail_now(input string name);
        n_total++;
        $display("FAIL %s: event occurred, expected none", name);
    endtask

    task automatic monitor();
        vec_t e;
        forever begin
            @(negedge clk);
            cyc++;
            if (writeM) mem[address[7:0]] = data;
            if (bus.i_ack || bus.d_ack) chk("ack_exclusive", {31'd0, bus.i_ack & bus.d_ack}, 0);
            if (readM || writeM) begin
                n_strobe++;
                chk("strobe_exclusive", {31'd0, readM & writeM}, 0);
                if (sb_q.size() == 0) begin
                    fail_now("strobe_without_request");
                end else begin
                    e = sb_q[0];
                    chk("strobe_address", address, e.addr);
                    chk("strobe_kind", {31'd0, writeM}, {31'd0, e.we});
                    if (writeM) chk("write_data", data, e.wdata);
                end
            end
            if (bus.i_ack || bus.d_ack) begin
                if (sb_q.size() == 0) begin
                    fail_now("ack_without_request");
                end else begin
                    e = sb_q.pop_front();
                    chk("ack_owner", {31'd0, bus.d_ack}, {31'd0, e.is_d});
                    chk("ack_rdata", bus.rdata, e.exp_rdata);
                    chk("ack_address", address, e.addr);
                    chk("strobe_cycles", n_strobe, LAT);
                    if (e.we) chk("data_released", data, KEEP);
                    if (e.is_d) begin
                        chk("d_cnt", bus.d_cnt, m_d);
                        m_d = m_d + CW'(1);
                    end else begin
                        chk("i_cnt", bus.i_cnt, m_i);
                        m_i = m_i + CW'(1);
                    end
                end
                n_strobe = 0;
                n_acks++;
                ack_cyc = cyc;
            end
        end
    endtask

    task automatic wait_ack(input int target, output bit got);
        got = 1'b0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            #1;
            if (n_acks >= target) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) fail_now("ack_timeout");
    endtask

    task automatic push(input logic is_d, input logic we, input logic [15:0] addr,
                        input logic [15:0] wdata, input logic [15:0] exp_rd);
        vec_t e;
        e.is_d = is_d;
        e.we = we;
        e.addr = addr;
        e.wdata = wdata;
        e.exp_rdata = exp_rd;
        sb_q.push_back(e);
    endtask

    // Ack is expected L+1 cycles after the cycle in which the request was driven.
    task automatic do_access(input logic is_d, input logic we, input logic [15:0] addr,
                             input logic [15:0] wdata, input logic [15:0] exp_rd);
        int t0;
        bit got;
        @(posedge clk);
        #2;
        if (is_d) begin
            bus.d_req = 1'b1; bus.d_we = we; bus.d_addr = addr; bus.d_wdata = wdata;
            bus.i_addr = 16'($urandom);
        end else begin
            bus.i_req = 1'b1; bus.i_addr = addr;
            bus.d_we = 1'($urandom); bus.d_addr = 16'($urandom); bus.d_wdata = 16'($urandom);
        end
        push(is_d, we, addr, wdata, exp_rd);
        t0 = cyc;
        wait_ack(n_acks + 1, got);
        if (got) chk("ack_latency", ack_cyc, t0 + LAT + 2);
        bus.i_req = 1'b0;
        bus.d_req = 1'b0;
    endtask

    task automatic assert_reset();
        reset = 1'b1;
        sb_q.delete();
        m_i = '0;
        m_d = '0;
        n_strobe = 0;
        #1;
        chk("rst_readM", {31'd0, readM}, 0);
        chk("rst_writeM", {31'd0, writeM}, 0);
        chk("rst_i_ack", {31'd0, bus.i_ack}, 0);
        chk("rst_d_ack", {31'd0, bus.d_ack}, 0);
        chk("rst_rdata", bus.rdata, 0);
        chk("rst_i_cnt", bus.i_cnt, 0);
        chk("rst_d_cnt", bus.d_cnt, 0);
        chk("rst_data_z", data, KEEP);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        int prev;
        int base;
        bit got;
        n_pass = 0; n_total = 0; cyc = 0; n_acks = 0; ack_cyc = 0; n_strobe = 0;
        m_i = '0; m_d = '0;
        bus.i_req = 1'b0; bus.i_addr = '0;
        bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;
        for (int a = 0; a < 256; a++) mem[a] = pat(a);
        mem[8'h10] = 16'hABCD;
        mem[8'h11] = 16'h0F0F;
        mem[8'hFF] = 16'h8001;

        tbl[0] = '{1'b0, 1'b0, 16'h0010, 16'h0000, 16'hABCD};
        tbl[1] = '{1'b1, 1'b1, 16'h0020, 16'h1234, 16'hABCD};
        tbl[2] = '{1'b1, 1'b0, 16'h0020, 16'h0000, 16'h1234};
        tbl[3] = '{1'b0, 1'b0, 16'h0020, 16'h0000, 16'h1234};
        tbl[4] = '{1'b1, 1'b1, 16'h0030, 16'hBEEF, 16'h1234};
        tbl[5] = '{1'b0, 1'b0, 16'h0011, 16'h0000, 16'h0F0F};
        tbl[6] = '{1'b1, 1'b0, 16'h0030, 16'h0000, 16'hBEEF};
        tbl[7] = '{1'b1, 1'b1, 16'h0010, 16'h0000, 16'hBEEF};
        tbl[8] = '{1'b0, 1'b0, 16'h0010, 16'h0000, 16'h0000};
        tbl[9] = '{1'b1, 1'b0, 16'h00FF, 16'h0000, 16'h8001};

        reset = 1'b1;
        fork
            monitor();
        join_none
        #3;
        assert_reset();
        chk("rst_address", address, 0);
        @(posedge clk);
        #2;
        reset = 1'b0;

        for (int v = 0; v < 10; v++) begin
            do_access(tbl[v].is_d, tbl[v].we, tbl[v].addr, tbl[v].wdata, tbl[v].exp_rdata);
        end

        // Both requesters held from reset: D first, then strict alternation.
        @(posedge clk);
        #2;
        assert_reset();
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 16'h0030;
        bus.i_req = 1'b1; bus.i_addr = 16'h0011;
        for (int k = 0; k < 2; k++) begin
            push(1'b1, 1'b0, 16'h0030, 16'h0000, 16'hBEEF);
            push(1'b0, 1'b0, 16'h0011, 16'h0000, 16'h0F0F);
        end
        @(posedge clk);
        #2;
        reset = 1'b0;
        t0 = cyc;
        prev = t0 + 1 + LAT + 1 - (LAT + 2);
        for (int k = 0; k < 4; k++) begin
            wait_ack(n_acks + 1, got);
            if (!got) break;
            chk("contend_spacing", ack_cyc - prev, LAT + 2);
            prev = ack_cyc;
        end
        bus.d_req = 1'b0;
        bus.i_req = 1'b0;

        // Request dropped after one cycle must still complete and ack.
        @(posedge clk);
        #2;
        bus.i_req = 1'b1; bus.i_addr = 16'h0010;
        push(1'b0, 1'b0, 16'h0010, 16'h0000, 16'h0000);
        t0 = cyc;
        @(posedge clk);
        #2;
        bus.i_req = 1'b0;
        bus.i_addr = 16'h0099;
        wait_ack(n_acks + 1, got);
        if (got) chk("dropped_req_latency", ack_cyc, t0 + LAT + 2);

        // Reset in BUSY of a D read abandons it; held request restarts afresh.
        @(posedge clk);
        #2;
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 16'h0020;
        push(1'b1, 1'b0, 16'h0020, 16'h0000, 16'h1234);
        @(posedge clk);
        #2;
        chk("busy_readM", {31'd0, readM}, 1);
        base = n_acks;
        assert_reset();
        @(posedge clk);
        #2;
        chk("no_ack_in_reset", n_acks, base);
        reset = 1'b0;
        push(1'b1, 1'b0, 16'h0020, 16'h0000, 16'h1234);
        t0 = cyc;
        wait_ack(n_acks + 1, got);
        if (got) chk("restart_latency", ack_cyc, t0 + LAT + 2);
        bus.d_req = 1'b0;

        // Sixteen I reads wrap the 4-bit I counter back to zero.
        @(posedge clk);
        #2;
        assert_reset();
        @(posedge clk);
        #2;
        reset = 1'b0;
        for (int k = 0; k < 16; k++) begin
            do_access(1'b0, 1'b0, 16'(16'h0040 + k), 16'h0000, pat(16'h0040 + k));
        end
        @(posedge clk);
        #2;
        chk("wrap_i_cnt", bus.i_cnt, 0);
        chk("wrap_d_cnt", bus.d_cnt, 0);
        chk("queue_drained", sb_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
